mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the processor's instruction-fetch port and its load/store port.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port and the load/store port.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_port_arbiter #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 7
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_wr,
   input  logic [63:0] d_wdata,
   input  logic [7:0]  d_wmask,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic [31:0] m_addr,
   output logic        m_wr,
   output logic [63:0] m_wdata,
   output logic [7:0]  m_wmask,
   input  logic [31:0] m_rdata,
   input  logic        m_ack,
   output logic        err
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [31:0]      TIMEOUT_DATA = 32'hDEAD_BEEF;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             m_req_q, m_req_d;
   logic [31:0]      m_addr_q, m_addr_d;
   logic             m_wr_q, m_wr_d;
   logic [63:0]      m_wdata_q, m_wdata_d;
   logic [7:0]       m_wmask_q, m_wmask_d;
   logic             i_ack_q, i_ack_d;
   logic [31:0]      i_rdata_q, i_rdata_d;
   logic             d_ack_q, d_ack_d;
   logic [31:0]      d_rdata_q, d_rdata_d;
   logic             err_q, err_d;
   logic             grant_any;
   logic             grant_data;
   logic             timeout;
   logic             finish;
`ifdef ARB_RR_EN
   logic             last_data_q, last_data_d;  // 1 = most recent grant went to the data port
`endif

   assign grant_any = i_req | d_req;
   assign timeout   = ~m_ack & (cnt_q == CNT_LAST);
   assign finish    = m_ack | timeout;

   always_comb begin
      grant_data = d_req;
`ifdef ARB_RR_EN
      if (i_req && d_req) grant_data = ~last_data_q;
`endif
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:           if (grant_any) state_d = grant_data ? BUSY_D : BUSY_I;
         BUSY_I, BUSY_D: if (finish)    state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      m_req_d   = m_req_q;
      m_addr_d  = m_addr_q;
      m_wr_d    = m_wr_q;
      m_wdata_d = m_wdata_q;
      m_wmask_d = m_wmask_q;
      i_ack_d   = 1'b0;
      i_rdata_d = i_rdata_q;
      d_ack_d   = 1'b0;
      d_rdata_d = d_rdata_q;
      err_d     = err_q;
`ifdef ARB_RR_EN
      last_data_d = last_data_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (grant_any) begin
               m_req_d = 1'b1;
`ifdef ARB_RR_EN
               last_data_d = grant_data;
`endif
               if (grant_data) begin
                  m_addr_d  = d_addr;
                  m_wr_d    = d_wr;
                  m_wdata_d = d_wdata;
                  m_wmask_d = d_wmask;
               end else begin
                  m_addr_d  = i_addr;
                  m_wr_d    = 1'b0;
                  m_wdata_d = '0;
                  m_wmask_d = '0;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (finish) begin
               // An abort still acks the requester so the core never stalls forever.
               m_req_d = 1'b0;
               cnt_d   = '0;
               if (!m_ack) err_d = 1'b1;
               if (state_q == BUSY_I) begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = m_ack ? m_rdata : TIMEOUT_DATA;
               end else begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = m_ack ? m_rdata : TIMEOUT_DATA;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q     <= '0;
         m_req_q   <= 1'b0;
         m_addr_q  <= '0;
         m_wr_q    <= 1'b0;
         m_wdata_q <= '0;
         m_wmask_q <= '0;
         i_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_ack_q   <= 1'b0;
         d_rdata_q <= '0;
         err_q     <= 1'b0;
`ifdef ARB_RR_EN
         last_data_q <= 1'b0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         m_req_q   <= m_req_d;
         m_addr_q  <= m_addr_d;
         m_wr_q    <= m_wr_d;
         m_wdata_q <= m_wdata_d;
         m_wmask_q <= m_wmask_d;
         i_ack_q   <= i_ack_d;
         i_rdata_q <= i_rdata_d;
         d_ack_q   <= d_ack_d;
         d_rdata_q <= d_rdata_d;
         err_q     <= err_d;
`ifdef ARB_RR_EN
         last_data_q <= last_data_d;
`endif
      end
   end

   assign m_req   = m_req_q;
   assign m_addr  = m_addr_q;
   assign m_wr    = m_wr_q;
   assign m_wdata = m_wdata_q;
   assign m_wmask = m_wmask_q;
   assign i_ack   = i_ack_q;
   assign i_rdata = i_rdata_q;
   assign d_ack   = d_ack_q;
   assign d_rdata = d_rdata_q;
   assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (grant rules, latched payload, rdata holding).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int TIMEOUT_CYC = 64;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic [31:0] d_addr = '0;
   logic        d_wr = 1'b0;
   logic [63:0] d_wdata = '0;
   logic [7:0]  d_wmask = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        m_req;
   logic [31:0] m_addr;
   logic        m_wr;
   logic [63:0] m_wdata;
   logic [7:0]  m_wmask;
   logic [31:0] m_rdata = '0;
   logic        m_ack = 1'b0;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;
   bit tb_last_data = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .nrst(nrst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_req(m_req), .m_addr(m_addr), .m_wr(m_wr), .m_wdata(m_wdata), .m_wmask(m_wmask),
      .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
   );

   function automatic bit pick_data(input bit ri, input bit rd);
      bit win;
      win = rd;
      if (ri && rd) begin
`ifdef ARB_RR_EN
         win = !tb_last_data;
`endif
      end
      return win;
   endfunction

   task automatic apply_reset();
      nrst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_wr = 1'b0;
      d_wdata = '0; d_wmask = '0; m_rdata = '0; m_ack = 1'b0;
      tb_last_data = 1'b0;
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
   endtask

   task automatic test_reset();
      nrst = 1'b0; i_req = 1'b1; d_req = 1'b1; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      n_checks++; if ({m_req, m_addr, m_wr, m_wdata, m_wmask, i_ack, i_rdata, d_ack, d_rdata, err} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got m_req=%b m_addr=%h i_ack=%b d_ack=%b err=%b required all zero", m_req, m_addr, i_ack, d_ack, err); end
      apply_reset();
      n_checks++; if ({m_req, i_ack, d_ack, err} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_release got %b required 0000", {m_req, i_ack, d_ack, err}); end
   endtask

   task automatic test_fetch();
      i_req = 1'b1; i_addr = 32'h40;
      @(posedge clk); #1;
      n_checks++; if ({m_req, m_addr, m_wr, m_wdata, m_wmask} !== {1'b1, 32'h40, 1'b0, 64'h0, 8'h0}) begin
         n_fail++; $display("FAIL fetch_grant got req=%b addr=%h wr=%b wdata=%h wmask=%h required 1/40/0/0/0", m_req, m_addr, m_wr, m_wdata, m_wmask); end
      @(posedge clk); #1;
      n_checks++; if ({m_req, i_ack} !== 2'b10) begin
         n_fail++; $display("FAIL fetch_wait got req,ack=%b required 10", {m_req, i_ack}); end
      m_ack = 1'b1; m_rdata = 32'h0050_0093;
      @(posedge clk); #1;
      m_ack = 1'b0; i_req = 1'b0;
      n_checks++; if ({i_ack, d_ack, m_req, i_rdata} !== {3'b100, 32'h0050_0093}) begin
         n_fail++; $display("FAIL fetch_ack got i_ack=%b d_ack=%b m_req=%b i_rdata=%h required 1/0/0/00500093", i_ack, d_ack, m_req, i_rdata); end
      @(posedge clk); #1;
      n_checks++; if ({i_ack, i_rdata} !== {1'b0, 32'h0050_0093}) begin
         n_fail++; $display("FAIL fetch_pulse got i_ack=%b i_rdata=%h required 0/00500093", i_ack, i_rdata); end
   endtask

   task automatic test_store();
      logic [105:0] exp_m;
      exp_m = {1'b1, 32'h100, 1'b1, 64'h1122_3344_5566_7788, 8'h0F};
      d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h100; d_wdata = 64'h1122_3344_5566_7788; d_wmask = 8'h0F;
      @(posedge clk); #1;
      n_checks++; if ({m_req, m_addr, m_wr, m_wdata, m_wmask} !== exp_m) begin
         n_fail++; $display("FAIL store_grant got %h required %h", {m_req, m_addr, m_wr, m_wdata, m_wmask}, exp_m); end
      d_addr = 32'h0BAD_0000; d_wdata = '0; d_wmask = 8'hFF;
      @(posedge clk); #1;
      n_checks++; if ({m_req, m_addr, m_wr, m_wdata, m_wmask, d_ack} !== {exp_m, 1'b0}) begin
         n_fail++; $display("FAIL store_hold got %h required %h", {m_req, m_addr, m_wr, m_wdata, m_wmask, d_ack}, {exp_m, 1'b0}); end
      m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
      @(posedge clk); #1;
      m_ack = 1'b0; d_req = 1'b0;
      n_checks++; if ({d_ack, i_ack, m_req, d_rdata, i_rdata} !== {3'b100, 32'hCAFE_0001, 32'h0050_0093}) begin
         n_fail++; $display("FAIL store_ack got d_ack=%b i_ack=%b m_req=%b d_rdata=%h i_rdata=%h", d_ack, i_ack, m_req, d_rdata, i_rdata); end
      @(posedge clk); #1;
      n_checks++; if ({d_ack, i_ack} !== 2'b00) begin
         n_fail++; $display("FAIL store_pulse got %b required 00", {d_ack, i_ack}); end
   endtask

   task automatic test_spurious_ack();
      m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      m_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_checks++; if ({m_req, i_ack, d_ack, i_rdata, d_rdata} !== {3'b000, 32'h0050_0093, 32'hCAFE_0001}) begin
            n_fail++; $display("FAIL spurious_idle got req=%b i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h", m_req, i_ack, d_ack, i_rdata, d_rdata); end
         @(posedge clk); #1;
      end
      i_req = 1'b1; i_addr = 32'h80;
      @(posedge clk); #1;
      n_checks++; if ({m_req, m_addr} !== {1'b1, 32'h80}) begin
         n_fail++; $display("FAIL spurious_then_grant got req=%b addr=%h required 1/80", m_req, m_addr); end
      m_ack = 1'b1; m_rdata = 32'h0000_0013;
      @(posedge clk); #1;
      m_ack = 1'b0; i_req = 1'b0;
      n_checks++; if ({i_ack, i_rdata} !== {1'b1, 32'h13}) begin
         n_fail++; $display("FAIL spurious_then_ack got i_ack=%b i_rdata=%h required 1/13", i_ack, i_rdata); end
   endtask

   task automatic test_arbitration();
      bit exp_seq [4];
      bit seen, win_d;
`ifdef ARB_RR_EN
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      apply_reset();
      i_req = 1'b1; i_addr = 32'h1000; d_req = 1'b1; d_addr = 32'h2000; d_wr = 1'b0;
      for (int t = 0; t < 4; t++) begin
         seen = 1'b0;
         for (int w = 0; w < 4 && !seen; w++) begin
            @(posedge clk); #1;
            if (m_req === 1'b1) seen = 1'b1;
         end
         n_checks++;
         if (!seen) begin
            n_fail++; $display("FAIL arb_grant_%0d got no m_req within 4 cycles required a grant", t);
         end else begin
            win_d = (m_addr === 32'h2000);
            if (win_d !== exp_seq[t]) begin
               n_fail++; $display("FAIL arb_order_%0d got data_won=%b required %b", t, win_d, exp_seq[t]); end
            m_ack = 1'b1; m_rdata = 32'hA000_0000 + 32'(t);
            @(posedge clk); #1;
            m_ack = 1'b0;
            n_checks++; if ({i_ack, d_ack} !== (exp_seq[t] ? 2'b01 : 2'b10)) begin
               n_fail++; $display("FAIL arb_ack_%0d got i_ack,d_ack=%b required data=%b", t, {i_ack, d_ack}, exp_seq[t]); end
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      int hi, guard;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h300;
      @(posedge clk); #1;
      hi = (m_req === 1'b1) ? 1 : 0;
      guard = 0;
      while (m_req === 1'b1 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
         if (m_req === 1'b1) hi++;
      end
      n_checks++; if (hi != TIMEOUT_CYC) begin
         n_fail++; $display("FAIL timeout_len got %0d cycles required %0d", hi, TIMEOUT_CYC); end
      n_checks++; if ({d_ack, i_ack, err, d_rdata} !== {3'b101, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL timeout_abort got d_ack=%b i_ack=%b err=%b d_rdata=%h required 1/0/1/deadbeef", d_ack, i_ack, err, d_rdata); end
      d_req = 1'b0;
      i_req = 1'b1; i_addr = 32'h44;
      @(posedge clk); #1;
      n_checks++; if ({m_req, m_addr, d_ack, err} !== {1'b1, 32'h44, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL timeout_next_grant got req=%b addr=%h d_ack=%b err=%b", m_req, m_addr, d_ack, err); end
      m_ack = 1'b1; m_rdata = 32'h00A0_0113;
      @(posedge clk); #1;
      m_ack = 1'b0; i_req = 1'b0;
      n_checks++; if ({i_ack, i_rdata, err} !== {1'b1, 32'h00A0_0113, 1'b1}) begin
         n_fail++; $display("FAIL timeout_next_ack got i_ack=%b i_rdata=%h err=%b required 1/00a00113/1", i_ack, i_rdata, err); end
   endtask

   task automatic test_reset_mid();
      i_req = 1'b1; i_addr = 32'h200;
      @(posedge clk); #1;
      n_checks++; if (m_req !== 1'b1) begin
         n_fail++; $display("FAIL midrst_busy got m_req=%b required 1", m_req); end
      #2 nrst = 1'b0;
      #1;
      n_checks++; if ({m_req, m_addr, i_ack, d_ack, err, i_rdata} !== '0) begin
         n_fail++; $display("FAIL midrst_clear got req=%b addr=%h i_ack=%b err=%b i_rdata=%h required all 0", m_req, m_addr, i_ack, err, i_rdata); end
      tb_last_data = 1'b0;
      @(posedge clk); #1 nrst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if ({m_req, m_addr} !== {1'b1, 32'h200}) begin
         n_fail++; $display("FAIL midrst_regrant got req=%b addr=%h required 1/200", m_req, m_addr); end
      m_ack = 1'b1; m_rdata = 32'h0000_0077;
      @(posedge clk); #1;
      m_ack = 1'b0; i_req = 1'b0;
      n_checks++; if ({i_ack, i_rdata, err} !== {1'b1, 32'h77, 1'b0}) begin
         n_fail++; $display("FAIL midrst_ack got i_ack=%b i_rdata=%h err=%b required 1/77/0", i_ack, i_rdata, err); end
   endtask

   task automatic test_random();
      bit busy = 1'b0, gnt_d = 1'b0, exp_i, exp_d;
      int wait_c = 0;
      logic [105:0] exp_m = '0;
      logic [31:0] mdl_irdata = '0, mdl_drdata = '0;
      apply_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk); #1;
         exp_i = 1'b0; exp_d = 1'b0;
         if (busy) begin
            if (m_ack) begin
               busy = 1'b0;
               if (gnt_d) begin exp_d = 1'b1; mdl_drdata = m_rdata; end
               else begin exp_i = 1'b1; mdl_irdata = m_rdata; end
               n_checks++; if (m_req !== 1'b0) begin
                  n_fail++; $display("FAIL rand_release cyc=%0d got m_req=%b required 0", cyc, m_req); end
            end else begin
               n_checks++; if ({m_req, m_addr, m_wr, m_wdata, m_wmask} !== exp_m) begin
                  n_fail++; $display("FAIL rand_hold cyc=%0d got %h required %h", cyc, {m_req, m_addr, m_wr, m_wdata, m_wmask}, exp_m); end
            end
         end else if (i_req || d_req) begin
            gnt_d = pick_data(i_req, d_req);
            tb_last_data = gnt_d;
            busy = 1'b1;
            exp_m = gnt_d ? {1'b1, d_addr, d_wr, d_wdata, d_wmask} : {1'b1, i_addr, 1'b0, 64'h0, 8'h0};
            wait_c = $urandom_range(0, 3);
            n_checks++; if ({m_req, m_addr, m_wr, m_wdata, m_wmask} !== exp_m) begin
               n_fail++; $display("FAIL rand_grant cyc=%0d got %h required %h", cyc, {m_req, m_addr, m_wr, m_wdata, m_wmask}, exp_m); end
         end else begin
            n_checks++; if (m_req !== 1'b0) begin
               n_fail++; $display("FAIL rand_idle cyc=%0d got m_req=%b required 0", cyc, m_req); end
         end
         n_checks++; if ({i_ack, d_ack, i_rdata, d_rdata} !== {exp_i, exp_d, mdl_irdata, mdl_drdata}) begin
            n_fail++; $display("FAIL rand_ack cyc=%0d got i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h required %b %b %h %h",
                               cyc, i_ack, d_ack, i_rdata, d_rdata, exp_i, exp_d, mdl_irdata, mdl_drdata); end
         m_ack = 1'b0;
         if (busy) begin
            if (wait_c == 0) begin m_ack = 1'b1; m_rdata = $urandom; end
            else wait_c--;
         end else if ($urandom_range(0, 7) == 0) begin
            m_ack = 1'b1; m_rdata = $urandom;
         end
         if (exp_i) begin
            i_req = 1'($urandom_range(0, 1)); i_addr = $urandom;
         end else if (!i_req) begin
            if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
         end else if (busy && !gnt_d) begin
            if ($urandom_range(0, 3) == 0) i_addr = $urandom;
            if ($urandom_range(0, 15) == 0) i_req = 1'b0;
         end
         if (exp_d) begin
            d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wr = 1'($urandom_range(0, 1));
            d_wdata = {$urandom, $urandom}; d_wmask = 8'($urandom);
         end else if (!d_req) begin
            if ($urandom_range(0, 2) == 0) begin
               d_req = 1'b1; d_addr = $urandom; d_wr = 1'($urandom_range(0, 1));
               d_wdata = {$urandom, $urandom}; d_wmask = 8'($urandom);
            end
         end else if (busy && gnt_d) begin
            if ($urandom_range(0, 3) == 0) begin d_addr = $urandom; d_wdata = {$urandom, $urandom}; d_wmask = 8'($urandom); end
            if ($urandom_range(0, 15) == 0) d_req = 1'b0;
         end
      end
      i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_spurious_ack();
      test_arbitration();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
